// File: rtl/mips_mem_responder_pkg.sv
// Shared types and limits for the MIPS memory responder.
// Imported by the responder top and its storage array.
package mips_mem_responder_pkg;

  localparam int MIPS_PC_WIDTH        = 32;
  localparam int MIPS_DATA_WIDTH      = 32;
  localparam int MIPS_MEM_DEPTH_WORDS = 256;
  localparam int MIPS_MEM_MAX_LATENCY = 15;
  localparam int MIPS_MEM_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mips_mem_state_e;

  function automatic logic is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word storage for the responder: synchronous write,
// combinational read, contents undefined until written.
module mips_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [DATA_WIDTH-1:0]          rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_mem_responder.sv
// Unified I/D memory responder for the multi-cycle MIPS core:
// valid/ready request, programmable wait states, 1-cycle response.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = MIPS_PC_WIDTH,
  parameter int DATA_WIDTH  = MIPS_DATA_WIDTH,
  parameter int DEPTH_WORDS = MIPS_MEM_DEPTH_WORDS,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int CNTW = MIPS_MEM_CNT_WIDTH;

  generate
    if (!is_pow2(DEPTH_WORDS)) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two >= 2");
    end
    if (LATENCY < 0 || LATENCY > MIPS_MEM_MAX_LATENCY) begin : g_bad_lat
      $error("LATENCY out of range");
    end
  endgenerate

  mips_mem_state_e       state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  c_wr;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // With zero latency the commit edge is also the capture edge.
  always_comb begin
    c_wr    = wr_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == IDLE) begin
      c_wr    = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
  end

  assign c_err = (c_addr[1:0] != 2'b00) ||
                 ((c_addr >> (IDXW + 2)) != '0);

  mips_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (c_addr[IDXW+1:2]),
    .wdata_i (c_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    vld_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNTW'(LATENCY - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP) begin
      vld_d   = 1'b1;
      err_d   = c_err;
      rdata_d = (c_err || c_wr) ? '0 : mem_rdata;
      mem_we  = c_wr && !c_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed + randomized bench for mips_mem_responder,
// LATENCY=2 (index 0) and LATENCY=0 (index 1) instances.
module tb_mips_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rv   [2];
  logic        rwr  [2];
  logic        rrdy [2];
  logic        vld  [2];
  logic        err  [2];
  logic [31:0] raddr[2];
  logic [31:0] rwd  [2];
  logic [31:0] rd   [2];

  int checks = 0;
  int failures = 0;

  logic [31:0] model [int];

  mips_mem_responder #(.LATENCY(2)) u_l2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv[0]),
    .req_ready (rrdy[0]),
    .req_write (rwr[0]),
    .req_addr  (raddr[0]),
    .req_wdata (rwd[0]),
    .rsp_valid (vld[0]),
    .rsp_rdata (rd[0]),
    .rsp_err   (err[0])
  );

  mips_mem_responder #(.LATENCY(0)) u_l0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv[1]),
    .req_ready (rrdy[1]),
    .req_write (rwr[1]),
    .req_addr  (raddr[1]),
    .req_wdata (rwd[1]),
    .rsp_valid (vld[1]),
    .rsp_rdata (rd[1]),
    .rsp_err   (err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 256 words: bits [9:2] index, anything above must be zero.
  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 10) != 0);
  endfunction

  function automatic int key(input int w, input logic [31:0] a);
    return w * 1024 + int'(a[9:2]);
  endfunction

  task automatic access(input int w, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] sa, input logic [31:0] sd,
                        input string tag);
    int k;
    logic exp_e;
    logic [31:0] exp_d;
    exp_e = bad(a);
    exp_d = '0;
    if (!exp_e && !wr && model.exists(key(w, a)))
      exp_d = model[key(w, a)];
    @(negedge clk);
    chk({tag, ":ready"}, 32'(rrdy[w]), 32'd1);
    rv[w] = 1'b1; rwr[w] = wr; raddr[w] = a; rwd[w] = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        rv[w] = 1'b0; rwr[w] = ~wr; raddr[w] = sa; rwd[w] = sd;
      end
    end while (!vld[w] && k < 20);
    chk({tag, ":lat"}, 32'(k), (w == 0) ? 32'd3 : 32'd1);
    chk({tag, ":rdata"}, rd[w], exp_d);
    chk({tag, ":err"}, 32'(err[w]), 32'(exp_e));
    chk({tag, ":rdy_resp"}, 32'(rrdy[w]), 32'd0);
    @(negedge clk);
    chk({tag, ":vld_drop"}, 32'(vld[w]), 32'd0);
    chk({tag, ":hold"}, rd[w], exp_d);
    chk({tag, ":rdy_back"}, 32'(rrdy[w]), 32'd1);
    if (wr && !exp_e) model[key(w, a)] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      rv[w] = 1'b0; rwr[w] = 1'b0; raddr[w] = '0; rwd[w] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:ready", 32'(rrdy[0]), 32'd1);
    chk("rst:vld", 32'(vld[0]), 32'd0);
    chk("rst:rdata", rd[0], 32'd0);
    chk("rst:err", 32'(err[0]), 32'd0);
    chk("rst:ready_l0", 32'(rrdy[1]), 32'd1);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0, "st10");
    access(0, 1'b0, 32'h10, 32'h0, 32'h14, 32'h0, "ld10");
    chk("ld10:value", rd[0], 32'hDEADBEEF);

    access(0, 1'b1, 32'h0, 32'hA5A50001, 32'h4, 32'h0, "st0");
    access(0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, "ld13");
    chk("ld13:err", 32'(err[0]), 32'd1);
    access(0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, "ld400");
    chk("ld400:err", 32'(err[0]), 32'd1);
    access(0, 1'b1, 32'h400, 32'h99, 32'h0, 32'h0, "st400");
    access(0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, "ld0");
    chk("ld0:value", rd[0], 32'hA5A50001);

    access(0, 1'b1, 32'hC, 32'h0000CCCC, 32'h0, 32'h0, "stC");
    access(0, 1'b1, 32'h8, 32'h1234, 32'hC, 32'h5678, "st8");
    access(0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0, "ld8");
    chk("ld8:value", rd[0], 32'h1234);
    access(0, 1'b0, 32'hC, 32'h0, 32'h0, 32'h0, "ldC");
    chk("ldC:value", rd[0], 32'h0000CCCC);

    access(0, 1'b1, 32'h20, 32'h1111, 32'h0, 32'h0, "st20");
    access(0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, "ld10b");
    @(negedge clk);
    rv[0] = 1'b1; rwr[0] = 1'b1; raddr[0] = 32'h20; rwd[0] = 32'h2222;
    @(negedge clk);
    rv[0] = 1'b0;
    chk("rstw:in_wait", 32'(rrdy[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstw:ready", 32'(rrdy[0]), 32'd1);
    chk("rstw:vld", 32'(vld[0]), 32'd0);
    chk("rstw:rdata", rd[0], 32'd0);
    chk("rstw:err", 32'(err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0, "ld20");
    chk("ld20:old", rd[0], 32'h1111);

    access(1, 1'b1, 32'h0, 32'h00C0FFEE, 32'h0, 32'h0, "l0st0");
    access(1, 1'b1, 32'h4, 32'h44440004, 32'h0, 32'h0, "l0st4");
    @(negedge clk);
    rv[1] = 1'b1; rwr[1] = 1'b0; raddr[1] = 32'h0;
    @(negedge clk);
    chk("b2b:vld1", 32'(vld[1]), 32'd1);
    chk("b2b:rd1", rd[1], 32'h00C0FFEE);
    chk("b2b:rdy1", 32'(rrdy[1]), 32'd0);
    raddr[1] = 32'h4;
    @(negedge clk);
    chk("b2b:gap_vld", 32'(vld[1]), 32'd0);
    chk("b2b:gap_rdy", 32'(rrdy[1]), 32'd1);
    @(negedge clk);
    chk("b2b:vld2", 32'(vld[1]), 32'd1);
    chk("b2b:rd2", rd[1], 32'h44440004);
    chk("b2b:rdy2", 32'(rrdy[1]), 32'd0);
    rv[1] = 1'b0;
    @(negedge clk);
    chk("b2b:drop", 32'(vld[1]), 32'd0);
    @(negedge clk);
    chk("b2b:noreissue", 32'(vld[1]), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int w;
      int sel;
      logic wr;
      logic [31:0] a;
      w = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) << 2;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      else if (sel == 1) a = $urandom | 32'h400;
      if (!wr && !bad(a) && !model.exists(key(w, a))) wr = 1'b1;
      access(w, wr, a, $urandom, $urandom, $urandom, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
